// File: rtl/sort_pkg.sv
// Shared definitions for the 4-entry sorter and its stream-out stage.
// Element width, element count and FSM state encodings used for debug.
package sort_pkg;

    localparam int DIGIT  = 4;
    localparam int SORT_N = 4;

    // Stream-out FSM, one-hot
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_SEND = 2'b10
    } stream_state_e;

    // Sorter FSM encodings, exported so debug tooling can decode both blocks
    typedef enum logic [2:0] {
        SRT_IDLE = 3'd0,
        SRT_LOAD = 3'd1,
        SRT_CMP  = 3'd2,
        SRT_SWAP = 3'd3,
        SRT_DONE = 3'd4
    } sorter_state_e;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one flop of history, rise is combinational from din.
// Latency 0 (rise valid in the same cycle din goes high); no backpressure.
// Asynchronous active-low reset clears history so a level high after reset counts as an edge.
module edge_rise (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/sort_stream_out.sv
// Streams a captured 4-entry sorter frame one element per valid/ready beat.
// Latency 1 from done rising to first element; data/last/valid held while out_ready is low.
// A done edge during a frame is dropped and flagged via sticky overrun, except on the final beat.
module sort_stream_out
    import sort_pkg::*;
#(
    parameter int DIGIT = sort_pkg::DIGIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIGIT-1:0] s0,
    input  logic [DIGIT-1:0] s1,
    input  logic [DIGIT-1:0] s2,
    input  logic [DIGIT-1:0] s3,
    input  logic             done,
    input  logic             descend,
    input  logic             out_ready,
    input  logic             clear_overrun,
    output logic             out_valid,
    output logic [DIGIT-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             overrun
);

    stream_state_e    state;
    logic [DIGIT-1:0] frame_buf [SORT_N];
    logic             dir;
    logic [1:0]       idx;

    logic             done_rise;
    logic             transfer;
    logic             final_xfer;
    logic             capture;
    logic             ovr_set;
    logic [1:0]       idx_nxt;
    logic [DIGIT-1:0] first_elem;
    logic [DIGIT-1:0] next_elem;

    edge_rise u_done_edge (
        .clock (clock),
        .reset (reset),
        .din   (done),
        .rise  (done_rise)
    );

    assign transfer   = out_valid & out_ready;
    assign final_xfer = (state == ST_SEND) & transfer & (idx == 2'd3);
    // The final beat frees the buffer, so an edge there starts the next frame back-to-back
    assign capture    = done_rise & ((state == ST_IDLE) | final_xfer);
    assign ovr_set    = done_rise & (state == ST_SEND) & ~final_xfer;

    assign idx_nxt    = idx + 2'd1;
    assign first_elem = descend ? s3 : s0;
    assign next_elem  = dir ? frame_buf[2'd3 - idx_nxt] : frame_buf[idx_nxt];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            for (int i = 0; i < SORT_N; i++) begin
                frame_buf[i] <= '0;
            end
            dir       <= 1'b0;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (capture) begin
                frame_buf[0] <= s0;
                frame_buf[1] <= s1;
                frame_buf[2] <= s2;
                frame_buf[3] <= s3;
                dir          <= descend;
                idx          <= 2'd0;
                state        <= ST_SEND;
                out_valid    <= 1'b1;
                out_data     <= first_elem;
                out_last     <= 1'b0;
                busy         <= 1'b1;
            end else if (state == ST_SEND && transfer) begin
                if (idx == 2'd3) begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end else begin
                    idx      <= idx_nxt;
                    out_data <= next_elem;
                    out_last <= (idx_nxt == 2'd3);
                end
            end

            // Set wins over a coincident clear
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sort_stream_out.sv
// Directed bench for sort_stream_out: reset, ascending, descending with stall,
// level done, overrun/back-to-back, and reset mid-frame.
module tb_sort_stream_out;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic       done = 1'b0;
    logic       descend = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_overrun = 1'b0;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    sort_stream_out #(.DIGIT(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .s0            (s0),
        .s1            (s1),
        .s2            (s2),
        .s3            (s3),
        .done          (done),
        .descend       (descend),
        .out_ready     (out_ready),
        .clear_overrun (clear_overrun),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // valid, data, last, busy, overrun in one go
    task automatic check_out(input string tag, input logic v, input logic [3:0] d,
                             input logic l, input logic b, input logic o);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) check({tag, ".data"}, {28'd0, out_data}, {28'd0, d});
        check({tag, ".last"}, {31'd0, out_last}, {31'd0, l});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, ".ovr"}, {31'd0, overrun}, {31'd0, o});
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic desc);
        s0 = a; s1 = b; s2 = c; s3 = d; descend = desc;
    endtask

    initial begin
        int beats;
        int lasts;

        // 1 Reset
        tick(); tick(); tick();
        check("rst.data", {28'd0, out_data}, 32'd0);
        check_out("rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(); tick();
        check_out("idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // 2 Ascending, consumer always ready
        load(4'h1, 4'h3, 4'h7, 4'h9, 1'b0);
        out_ready = 1'b1;
        done = 1'b1;
        tick(); check_out("asc0", 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
        done = 1'b0;
        load(4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
        tick(); check_out("asc1", 1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
        tick(); check_out("asc2", 1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
        tick(); check_out("asc3", 1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
        tick(); check_out("asc_end", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // 3 Descending with a 3-cycle stall
        load(4'h2, 4'h4, 4'h5, 4'hE, 1'b1);
        done = 1'b1;
        tick(); check_out("dsc0", 1'b1, 4'hE, 1'b0, 1'b1, 1'b0);
        done = 1'b0;
        tick(); check_out("dsc1", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        tick(); check_out("stall1", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        tick(); check_out("stall2", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        tick(); check_out("stall3", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick(); check_out("dsc2", 1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
        tick(); check_out("dsc3", 1'b1, 4'h2, 1'b1, 1'b1, 1'b0);
        tick(); check_out("dsc_end", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // 4 Level done for 20 cycles -> one frame
        load(4'h0, 4'h1, 4'h2, 4'h3, 1'b0);
        done = 1'b1;
        beats = 0;
        lasts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid && out_ready) beats++;
            if (out_valid && out_last) lasts++;
        end
        done = 1'b0;
        check("level.beats", beats, 32'd4);
        check("level.lasts", lasts, 32'd1);
        check("level.ovr", {31'd0, overrun}, 32'd0);
        tick();

        // 5a Overrun: second edge at idx=1
        load(4'h0, 4'h1, 4'h2, 4'h3, 1'b0);
        done = 1'b1;
        tick(); check_out("ovr0", 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
        done = 1'b0;
        tick(); check_out("ovr1", 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
        load(4'hA, 4'hA, 4'hA, 4'hA, 1'b1);
        done = 1'b1;
        tick(); check_out("ovr2", 1'b1, 4'h2, 1'b0, 1'b1, 1'b1);
        done = 1'b0;
        tick(); check_out("ovr3", 1'b1, 4'h3, 1'b1, 1'b1, 1'b1);
        tick(); check_out("ovr_end", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        tick(); check_out("ovr_sticky", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        clear_overrun = 1'b1;
        tick(); check_out("ovr_clr", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        clear_overrun = 1'b0;

        // 5b Edge on the final transfer -> back-to-back frame
        load(4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
        done = 1'b1;
        tick(); check_out("b2b_a0", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        done = 1'b0;
        tick(); check_out("b2b_a1", 1'b1, 4'h6, 1'b0, 1'b1, 1'b0);
        tick(); check_out("b2b_a2", 1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
        tick(); check_out("b2b_a3", 1'b1, 4'h8, 1'b1, 1'b1, 1'b0);
        load(4'h9, 4'hA, 4'hB, 4'hC, 1'b1);
        done = 1'b1;
        tick(); check_out("b2b_b0", 1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
        done = 1'b0;
        tick(); check_out("b2b_b1", 1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
        tick(); check_out("b2b_b2", 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
        tick(); check_out("b2b_b3", 1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
        tick(); check_out("b2b_end", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // 6 Reset mid-frame at idx=2
        load(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        done = 1'b1;
        tick(); check_out("mid0", 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
        done = 1'b0;
        tick(); check_out("mid1", 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
        tick(); check_out("mid2", 1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst.data", {28'd0, out_data}, 32'd0);
        check_out("mid_rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick(); check_out("mid_after1", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(); check_out("mid_after2", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
